nwd_driver: RTL
===============

Name: nwd_driver

Overview:
- Initiator side of the existing iterative GCD (nwd) engine's init/fin interface.
- Takes operand pairs over a valid/ready request channel and loads them into the engine with a one-cycle `init` pulse.
- Watches `fin`, captures the result, and returns it over a valid/ready response channel.
- Guards the engine against non-terminating inputs: zero operands are bypassed, and a watchdog enforces a cycle limit.

Parameters:
- WIDTH, 16, operand/result width; must match the engine.
- MAX_CYCLES, 65536, watchdog limit in WAIT cycles before the job is aborted with an error.
- CNT_W, $clog2(MAX_CYCLES+1), watchdog counter width (derived, not overridden).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  operand pair present.
- req_ready  out  1  driver can accept a pair.
- req_a  in  WIDTH  first operand.
- req_b  in  WIDTH  second operand.
- res_valid  out  1  result present.
- res_ready  in  1  consumer takes the result.
- res_gcd  out  WIDTH  gcd(req_a, req_b); 0 on error.
- res_err  out  1  watchdog abort flag, qualified by res_valid.
- eng_init  out  1  to engine init.
- eng_in1  out  WIDTH  to engine in1.
- eng_in2  out  WIDTH  to engine in2.
- eng_out  in  WIDTH  from engine out.
- eng_fin  in  1  from engine fin (combinational a==b).

Behaviour:
- Reset state (asynchronous, all registers):
  - state=IDLE, req_ready=1, res_valid=0, res_gcd=0, res_err=0.
  - eng_init=0, eng_in1=0, eng_in2=0, watchdog=0.
- States: IDLE, LOAD, WAIT, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid, register operands to eng_in1/eng_in2.
  - If either operand is 0: go directly to DONE with res_gcd = a|b (gcd(0,x)=x, gcd(0,0)=0), res_err=0.
  - Otherwise go to LOAD.
- LOAD:
  - eng_init=1 for exactly this cycle; req_ready=0.
  - Engine registers operands at the end of this cycle. Next state WAIT; clear watchdog.
- WAIT:
  - eng_init=0. Each cycle sample eng_fin.
  - fin=1: capture eng_out into res_gcd, res_err=0, go to DONE.
  - fin=0: increment watchdog. If the count reaches MAX_CYCLES: res_gcd=0, res_err=1, go to DONE.
  - fin has priority over the watchdog in the same cycle.
- DONE:
  - res_valid=1. res_gcd and res_err are held stable while res_valid && !res_ready.
  - On res_ready: go to IDLE, res_valid=0.
  - No request is accepted in the same cycle as the result handoff.
- Latency:
  - Handshake in cycle 0, init in cycle 1, first fin sample in cycle 2.
  - res_valid rises in cycle 3+k, where k is the number of engine subtraction steps.
  - Zero-operand bypass: res_valid in cycle 1.
- eng_in1/eng_in2 are held constant from accept until return to IDLE.
- Reset mid-job: the driver aborts to IDLE with no result emitted. The engine has no reset and keeps stale state, which is harmless because every job reissues init.
- Equal non-zero operands: fin=1 at the first WAIT sample, so k=0.
- The driver never drives eng_init while in WAIT or DONE.

Optional Feature:
- Macro: NWD_DRIVER_CYCLES_EN.
- Defined:
  - Extra output port res_cycles [CNT_W-1:0] carrying the WAIT-cycle count of the returned job.
  - 0 for the zero-operand bypass; MAX_CYCLES on error.
  - Held together with res_gcd.
- Undefined: the port is absent and no count register is added beyond the watchdog.

Decomposition:
- Package nwd_pkg:
  - WIDTH default constant.
  - state typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE}.
  - Default MAX_CYCLES constant.
- One natural sub-module: nwd_watchdog.
  - Inputs: clear, enable.
  - Output: expired.
  - Counter CNT_W wide, saturating.

Test Plan:
- (48,18), res_ready=1, real engine → eng_init pulses once; res_gcd=6, res_err=0, res_valid 7 cycles after accept (k=4).
- (0,7) then (0,0) → bypass, no eng_init; res_gcd=7, then res_gcd=0, each valid 1 cycle after accept.
- (65535,1) with MAX_CYCLES=100 → res_err=1, res_gcd=0. With default MAX_CYCLES → res_gcd=1, res_err=0.
- (21,21) with res_ready low for 5 cycles → res_valid stays 1, res_gcd=21 stable, req_ready=0 throughout, handoff on the first res_ready.
- rst_n asserted during WAIT of (1000,3), then (12,8) → no result for the first job; second returns res_gcd=4; all outputs read reset values during reset.
- NWD_DRIVER_CYCLES_EN defined, (48,18) → res_cycles=4.

Source files
------------

// File: rtl/nwd_pkg.sv
// rtl/nwd_pkg.sv - shared constants and state type for the nwd engine driver
package nwd_pkg;

    localparam int NWD_WIDTH      = 16;
    localparam int NWD_MAX_CYCLES = 65536;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } nwd_state_e;

endpackage

// File: rtl/nwd_watchdog.sv
// rtl/nwd_watchdog.sv - saturating WAIT-cycle counter that flags the cycle limit
// The count output exists only when NWD_DRIVER_CYCLES_EN is defined.
module nwd_watchdog #(
    parameter int MAX_CYCLES = 65536,
    parameter int CNT_W      = $clog2(MAX_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
`ifdef NWD_DRIVER_CYCLES_EN
    output logic [CNT_W-1:0] count,
`endif
    output logic             expired
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != CNT_W'(MAX_CYCLES))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires on the enabled cycle whose increment brings the count to the limit.
    assign expired = enable && (cnt_q == CNT_W'(MAX_CYCLES - 1));

`ifdef NWD_DRIVER_CYCLES_EN
    assign count = cnt_q;
`endif

endmodule

// File: rtl/nwd_driver.sv
// rtl/nwd_driver.sv - init/fin initiator for the iterative gcd engine, with zero bypass and watchdog
// Optional res_cycles output enabled by NWD_DRIVER_CYCLES_EN.
module nwd_driver
    import nwd_pkg::*;
#(
    parameter int    WIDTH      = NWD_WIDTH,
    parameter int    MAX_CYCLES = NWD_MAX_CYCLES,
    localparam int   CNT_W      = $clog2(MAX_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_gcd,
    output logic             res_err,
`ifdef NWD_DRIVER_CYCLES_EN
    output logic [CNT_W-1:0] res_cycles,
`endif
    output logic             eng_init,
    output logic [WIDTH-1:0] eng_in1,
    output logic [WIDTH-1:0] eng_in2,
    input  logic [WIDTH-1:0] eng_out,
    input  logic             eng_fin
);

    nwd_state_e       state_q, state_d;
    logic [WIDTH-1:0] in1_q, in1_d;
    logic [WIDTH-1:0] in2_q, in2_d;
    logic [WIDTH-1:0] gcd_q, gcd_d;
    logic             err_q, err_d;
    logic             wd_clear;
    logic             wd_enable;
    logic             wd_expired;
`ifdef NWD_DRIVER_CYCLES_EN
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic [CNT_W-1:0] wd_count;
`endif

    assign wd_clear  = (state_q == LOAD);
    assign wd_enable = (state_q == WAIT) && !eng_fin;

    nwd_watchdog #(
        .MAX_CYCLES (MAX_CYCLES),
        .CNT_W      (CNT_W)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (wd_clear),
        .enable  (wd_enable),
`ifdef NWD_DRIVER_CYCLES_EN
        .count   (wd_count),
`endif
        .expired (wd_expired)
    );

    always_comb begin
        state_d = state_q;
        in1_d   = in1_q;
        in2_d   = in2_q;
        gcd_d   = gcd_q;
        err_d   = err_q;
`ifdef NWD_DRIVER_CYCLES_EN
        cycles_d = cycles_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    in1_d = req_a;
                    in2_d = req_b;
                    // A zero operand would never make the engine's a==b test fire.
                    if ((req_a == '0) || (req_b == '0)) begin
                        gcd_d   = req_a | req_b;
                        err_d   = 1'b0;
`ifdef NWD_DRIVER_CYCLES_EN
                        cycles_d = '0;
`endif
                        state_d = DONE;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (eng_fin) begin
                    gcd_d   = eng_out;
                    err_d   = 1'b0;
`ifdef NWD_DRIVER_CYCLES_EN
                    cycles_d = wd_count;
`endif
                    state_d = DONE;
                end else if (wd_expired) begin
                    gcd_d   = '0;
                    err_d   = 1'b1;
`ifdef NWD_DRIVER_CYCLES_EN
                    cycles_d = CNT_W'(MAX_CYCLES);
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            in1_q   <= '0;
            in2_q   <= '0;
            gcd_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
            gcd_q   <= gcd_d;
            err_q   <= err_d;
        end
    end

`ifdef NWD_DRIVER_CYCLES_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycles_q <= '0;
        end else begin
            cycles_q <= cycles_d;
        end
    end

    assign res_cycles = cycles_q;
`endif

    assign req_ready = (state_q == IDLE);
    assign res_valid = (state_q == DONE);
    assign eng_init  = (state_q == LOAD);
    assign eng_in1   = in1_q;
    assign eng_in2   = in2_q;
    assign res_gcd   = gcd_q;
    assign res_err   = err_q;

endmodule
